// File: rtl/mix_columns.sv
// AES MixColumns / InvMixColumns over the full 128-bit state.
// The four columns are transformed in parallel by a purely combinational
// GF(2^8) network and captured in a single output register, so the block
// has one cycle of latency and accepts a new state every cycle.
module mix_columns (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         inv,
  input  logic [127:0] in,
  output logic         out_valid,
  output logic [127:0] out
);

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Transform one 32-bit column; byte 0 (row 0) sits in the top byte.
  // The inverse coefficients 9, 11, 13 and 14 are assembled from the
  // x2/x4/x8 multiples, which the forward path also reuses for 2 and 3.
  function automatic logic [31:0] mix_column(input logic [31:0] col,
                                             input logic        inverse);
    logic [7:0] a   [4];
    logic [7:0] m1  [4];
    logic [7:0] m2  [4];
    logic [7:0] m3  [4];
    logic [7:0] m4  [4];
    logic [7:0] m8  [4];
    logic [7:0] m9  [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] b   [4];

    for (int r = 0; r < 4; r++) begin
      a[r]   = col[31-8*r -: 8];
      m1[r]  = a[r];
      m2[r]  = xtime(a[r]);
      m4[r]  = xtime(m2[r]);
      m8[r]  = xtime(m4[r]);
      m3[r]  = m2[r] ^ m1[r];
      m9[r]  = m8[r] ^ m1[r];
      m11[r] = m8[r] ^ m2[r] ^ m1[r];
      m13[r] = m8[r] ^ m4[r] ^ m1[r];
      m14[r] = m8[r] ^ m4[r] ^ m2[r];
    end

    if (inverse) begin
      b[0] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
      b[1] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
      b[2] = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
      b[3] = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
    end else begin
      b[0] = m2[0] ^ m3[1] ^ m1[2] ^ m1[3];
      b[1] = m1[0] ^ m2[1] ^ m3[2] ^ m1[3];
      b[2] = m1[0] ^ m1[1] ^ m2[2] ^ m3[3];
      b[3] = m3[0] ^ m1[1] ^ m1[2] ^ m2[3];
    end

    mix_column = {b[0], b[1], b[2], b[3]};
  endfunction

  logic [127:0] next_out;

  // Combinational transform of all four columns under the requested mode.
  always_comb begin
    // NOTE: default assignment first so no path through this block can
    // leave next_out unassigned and infer a latch.
    next_out = '0;
    for (int c = 0; c < 4; c++) begin
      next_out[127-32*c -: 32] = mix_column(in[127-32*c -: 32], inv);
    end
  end

  // Output register: load on in_valid, hold otherwise; valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data register is cleared as well as the valid flag, so a
      // reset mid-stream leaves no stale state visible on out.
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      out_valid <= in_valid;
      if (in_valid) begin
        out <= next_out;
      end
    end
  end

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: directed FIPS-197 style vectors,
// mode toggling, async reset and a forward/inverse round trip, with a
// matrix-over-GF(2^8) reference model checked against the DUT every cycle.
module tb_mix_columns;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         inv;
  logic [127:0] in;
  logic         out_valid;
  logic [127:0] out;

  int checks = 0;
  int errors = 0;

  mix_columns dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .inv       (inv),
    .in        (in),
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // General GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Reference: each column times the circulant matrix whose first row is
  // {2,3,1,1} (forward) or {14,11,13,9} (inverse).
  function automatic logic [127:0] model_mix(input logic [127:0] s, input logic mode);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (mode) base = '{8'd14, 8'd11, 8'd13, 8'd9};
    else      base = '{8'd2, 8'd3, 8'd1, 8'd1};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(base[(k - row + 4) % 4], s[127-32*c-8*k -: 8]);
        end
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected output timing: one-cycle register, async clear.
  logic [127:0] exp_out;
  logic         exp_valid;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_out   <= '0;
      exp_valid <= 1'b0;
    end else begin
      exp_valid <= in_valid;
      if (in_valid) exp_out <= model_mix(in, inv);
    end
  end

  // Continuous comparison, sampled on the falling edge.
  always @(negedge clk) begin
    check("cyc_out_valid", {127'd0, out_valid}, {127'd0, exp_valid});
    check("cyc_out", out, exp_out);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] v, input logic m);
    in_valid = 1'b1;
    inv      = m;
    in       = v;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  localparam logic [127:0] FIPS_IN  = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
  localparam logic [127:0] FIPS_OUT = 128'h046681E5E0CB199A48F8D37A2806264C;
  localparam logic [127:0] COL_IN   = 128'hDB135345F20A225C01010101C6C6C6C6;
  localparam logic [127:0] COL_OUT  = 128'h8E4DA1BC9FDC589D01010101C6C6C6C6;
  localparam logic [127:0] COL2_IN  = 128'hD4D4D4D52D26314C00000000FFFFFFFF;
  localparam logic [127:0] COL2_OUT = 128'hD5D5D7D64D7EBDF800000000FFFFFFFF;

  initial begin
    logic [127:0] x;
    logic [127:0] y;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    inv      = 1'b0;
    in       = '0;

    // Pin the reference model to hand-computed vectors.
    check("model_fwd_fips", model_mix(FIPS_IN, 1'b0), FIPS_OUT);
    check("model_inv_fips", model_mix(FIPS_OUT, 1'b1), FIPS_IN);
    check("model_fwd_col2", model_mix(COL2_IN, 1'b0), COL2_OUT);

    #12;
    check("reset_out", out, 128'h0);
    check("reset_valid", {127'd0, out_valid}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Forward vectors.
    drive(FIPS_IN, 1'b0);
    step();
    check("fwd_fips", out, FIPS_OUT);
    check("fwd_fips_valid", {127'd0, out_valid}, 128'h1);
    drive(COL_IN, 1'b0);
    step();
    check("fwd_col", out, COL_OUT);
    drive(COL2_IN, 1'b0);
    step();
    check("fwd_col2", out, COL2_OUT);

    // Inverse vectors.
    drive(FIPS_OUT, 1'b1);
    step();
    check("inv_fips", out, FIPS_IN);
    drive(COL_OUT, 1'b1);
    step();
    check("inv_col", out, COL_IN);

    // Back-to-back with alternating mode, then idle hold.
    idle();
    step();
    drive(FIPS_IN, 1'b0);
    step();
    check("b2b_0", out, FIPS_OUT);
    check("b2b_0_valid", {127'd0, out_valid}, 128'h1);
    drive(COL_OUT, 1'b1);
    step();
    check("b2b_1", out, COL_IN);
    check("b2b_1_valid", {127'd0, out_valid}, 128'h1);
    drive(COL2_IN, 1'b0);
    step();
    check("b2b_2", out, COL2_OUT);
    check("b2b_2_valid", {127'd0, out_valid}, 128'h1);
    idle();
    in = FIPS_IN;
    step();
    check("idle_hold", out, COL2_OUT);
    check("idle_valid", {127'd0, out_valid}, 128'h0);
    step();
    check("idle_hold2", out, COL2_OUT);

    // Asynchronous reset mid-stream with a nonzero output pending.
    drive(FIPS_IN, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 128'h0);
    check("async_rst_valid", {127'd0, out_valid}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(COL_IN, 1'b0);
    step();
    check("post_rst_out", out, COL_OUT);
    check("post_rst_valid", {127'd0, out_valid}, 128'h1);

    // Random round trip: forward, feed the result back through inverse.
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      drive(x, 1'b0);
      step();
      y = out;
      drive(y, 1'b1);
      step();
      check("round_trip", out, x);
    end

    idle();
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
